coin_start_sequencer: RTL and testbench



---
 rtl/coin_start_sequencer.sv | 150 +++++++++++++++
 tb/tb_coin_start_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/coin_start_sequencer.sv
// Converts raw coin/start buttons into timed COIN_SW and START_GAME pulses.
// Coins queue up and only reach the core while it reports no credit.
module coin_start_sequencer #(
   parameter int COIN_PULSE_CNT  = 600000,
   parameter int COIN_GAP_CNT    = 300000,
   parameter int START_PULSE_CNT = 60000,
   parameter int QUEUE_DEPTH     = 3
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic [1:0] coin_req,
   input  logic [1:0] start_req,
   input  logic       credit_light_n,
   output logic       coin_sw,
   output logic       start_game,
   output logic [2:0] coin_pending,
   output logic       busy,
   output logic       coin_drop
);

   localparam int MAX_AB  = (COIN_PULSE_CNT > COIN_GAP_CNT) ? COIN_PULSE_CNT : COIN_GAP_CNT;
   localparam int MAX_CNT = (MAX_AB > START_PULSE_CNT) ? MAX_AB : START_PULSE_CNT;
   localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   localparam logic [CW-1:0] COIN_LAST  = CW'(COIN_PULSE_CNT - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(COIN_GAP_CNT - 1);
   localparam logic [CW-1:0] START_LAST = CW'(START_PULSE_CNT - 1);
   localparam logic [3:0]    QD         = 4'(QUEUE_DEPTH);

   typedef enum logic [1:0] {IDLE, COIN_ON, COIN_GAP, START_ON} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    coin_s1, coin_s2, coin_prev;
   logic [1:0]    start_s1, start_s2, start_prev;
   logic          cl_s1, cl_s;
   logic          start_flag;

   logic [1:0] coin_edge;
   logic [1:0] n_edges;
   logic       start_edge;
   logic       go_coin, go_start, drop_start;
   logic [3:0] sum;

   // Credit light resets to 1 (no credit) so nothing fires before the core speaks.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         coin_s1    <= '0;
         coin_s2    <= '0;
         coin_prev  <= '0;
         start_s1   <= '0;
         start_s2   <= '0;
         start_prev <= '0;
         cl_s1      <= 1'b1;
         cl_s       <= 1'b1;
      end else begin
         coin_s1    <= coin_req;
         coin_s2    <= coin_s1;
         coin_prev  <= coin_s2;
         start_s1   <= start_req;
         start_s2   <= start_s1;
         start_prev <= start_s2;
         cl_s1      <= credit_light_n;
         cl_s       <= cl_s1;
      end
   end

   assign coin_edge  = coin_s2 & ~coin_prev;
   assign n_edges    = {1'b0, coin_edge[0]} + {1'b0, coin_edge[1]};
   assign start_edge = |(start_s2 & ~start_prev);

   assign go_start   = (state == IDLE) && !cl_s && start_flag;
   assign drop_start = (state == IDLE) &&  cl_s && start_flag;
   assign go_coin    = (state == IDLE) &&  cl_s && (coin_pending != 3'd0);

   // go_coin implies pending > 0, so the subtraction never wraps.
   assign sum = {1'b0, coin_pending} + {2'b00, n_edges} - {3'b000, go_coin};

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         coin_pending <= '0;
         coin_drop    <= 1'b0;
         start_flag   <= 1'b0;
      end else begin
         coin_pending <= (sum > QD) ? QD[2:0] : sum[2:0];
         coin_drop    <= (sum > QD);
         if (go_start || drop_start)
            start_flag <= start_edge;
         else if (start_edge)
            start_flag <= 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         coin_sw    <= 1'b0;
         start_game <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (go_start) begin
                  state      <= START_ON;
                  start_game <= 1'b1;
               end else if (go_coin) begin
                  state   <= COIN_ON;
                  coin_sw <= 1'b1;
               end
            end
            COIN_ON: begin
               if (cnt == COIN_LAST) begin
                  state   <= COIN_GAP;
                  cnt     <= '0;
                  coin_sw <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            COIN_GAP: begin
               if (cnt == GAP_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            START_ON: begin
               if (cnt == START_LAST) begin
                  state      <= IDLE;
                  cnt        <= '0;
                  start_game <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               cnt        <= '0;
               coin_sw    <= 1'b0;
               start_game <= 1'b0;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_coin_start_sequencer.sv
// Directed bench for coin_start_sequencer with short pulse counts (8/4/6, depth 3).
module tb_coin_start_sequencer;

   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic [1:0] coin_req;
   logic [1:0] start_req;
   logic       credit_light_n;
   logic       coin_sw, start_game, busy, coin_drop;
   logic [2:0] coin_pending;

   int total = 0, passed = 0;
   int sw_hi = 0, sg_hi = 0, drop_n = 0;
   int sw0, sg0, d0;

   coin_start_sequencer #(
      .COIN_PULSE_CNT(8), .COIN_GAP_CNT(4), .START_PULSE_CNT(6), .QUEUE_DEPTH(3)
   ) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .coin_req(coin_req), .start_req(start_req),
      .credit_light_n(credit_light_n), .coin_sw(coin_sw), .start_game(start_game),
      .coin_pending(coin_pending), .busy(busy), .coin_drop(coin_drop)
   );

   always #5 clk_sys = ~clk_sys;

   // Count high cycles of each pulse output, sampled mid-cycle.
   always @(negedge clk_sys) begin
      if (coin_sw)    sw_hi++;
      if (start_game) sg_hi++;
      if (coin_drop)  drop_n++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      tick(1);
   endtask

   initial begin
      reset_n = 1'b0; coin_req = 2'b00; start_req = 2'b00; credit_light_n = 1'b1;
      tick(2);
      chk("rst_coin_sw", coin_sw, 0);
      chk("rst_start_game", start_game, 0);
      chk("rst_pending", coin_pending, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop", coin_drop, 0);
      reset_n = 1'b1;
      tick(2);

      // 1: single coin, no credit
      sw0 = sw_hi;
      coin_req = 2'b01;
      tick(3);
      chk("t1_pending_c3", coin_pending, 1);
      chk("t1_sw_c3", coin_sw, 0);
      coin_req = 2'b00;
      tick(1);
      chk("t1_sw_c4", coin_sw, 1);
      chk("t1_pending_c4", coin_pending, 0);
      tick(7);
      chk("t1_sw_c11", coin_sw, 1);
      tick(1);
      chk("t1_sw_c12", coin_sw, 0);
      chk("t1_busy_c12", busy, 1);
      tick(3);
      chk("t1_busy_c15", busy, 1);
      tick(1);
      chk("t1_busy_c16", busy, 0);
      chk("t1_sw_width", sw_hi - sw0, 8);

      // 2: coins queued behind credit, released when credit clears
      credit_light_n = 1'b0;
      tick(3);
      coin_req = 2'b01; tick(2);
      coin_req = 2'b00; tick(2);
      coin_req = 2'b01; tick(2);
      coin_req = 2'b00; tick(6);
      chk("t2_pending_q", coin_pending, 2);
      chk("t2_sw_blocked", coin_sw, 0);
      chk("t2_busy_blocked", busy, 0);
      sw0 = sw_hi;
      credit_light_n = 1'b1;
      tick(2);
      chk("t2_sw_e2", coin_sw, 0);
      tick(1);
      chk("t2_sw_e3", coin_sw, 1);
      chk("t2_pending_e3", coin_pending, 1);
      tick(7);
      chk("t2_sw_e10", coin_sw, 1);
      tick(1);
      chk("t2_sw_gap_e11", coin_sw, 0);
      tick(4);
      chk("t2_sw_gap_e15", coin_sw, 0);
      tick(1);
      chk("t2_sw_e16", coin_sw, 1);
      chk("t2_pending_e16", coin_pending, 0);
      tick(8);
      chk("t2_sw_e24", coin_sw, 0);
      tick(4);
      chk("t2_busy_end", busy, 0);
      chk("t2_sw_width", sw_hi - sw0, 16);

      // 3: saturation
      do_reset();
      credit_light_n = 1'b0;
      tick(3);
      d0 = drop_n;
      coin_req = 2'b11; tick(2);
      coin_req = 2'b00; tick(1);
      chk("t3_pending_both", coin_pending, 2);
      tick(1);
      coin_req = 2'b01; tick(2);
      coin_req = 2'b00; tick(1);
      chk("t3_pending_full", coin_pending, 3);
      chk("t3_no_drop_yet", coin_drop, 0);
      tick(1);
      coin_req = 2'b10; tick(2);
      coin_req = 2'b00; tick(1);
      chk("t3_pending_sat", coin_pending, 3);
      chk("t3_drop_pulse", coin_drop, 1);
      tick(1);
      chk("t3_drop_low", coin_drop, 0);
      chk("t3_drop_count", drop_n - d0, 1);

      // 4: start with credit
      do_reset();
      credit_light_n = 1'b0;
      tick(3);
      sg0 = sg_hi; sw0 = sw_hi;
      start_req = 2'b10; tick(2);
      start_req = 2'b00; tick(1);
      chk("t4_sg_c3", start_game, 0);
      tick(1);
      chk("t4_sg_c4", start_game, 1);
      chk("t4_busy_c4", busy, 1);
      tick(5);
      chk("t4_sg_c9", start_game, 1);
      tick(1);
      chk("t4_sg_c10", start_game, 0);
      tick(2);
      chk("t4_sg_width", sg_hi - sg0, 6);
      chk("t4_no_coin", sw_hi - sw0, 0);

      // 5: start without credit is dropped
      credit_light_n = 1'b1;
      do_reset();
      tick(2);
      sg0 = sg_hi;
      start_req = 2'b01; tick(2);
      start_req = 2'b00; tick(2);
      chk("t5_sg_c4", start_game, 0);
      chk("t5_busy_c4", busy, 0);
      credit_light_n = 1'b0;
      tick(12);
      chk("t5_no_late_start", sg_hi - sg0, 0);
      chk("t5_busy_end", busy, 0);

      // 6: reset during a coin pulse
      do_reset();
      tick(2);
      coin_req = 2'b11; tick(2);
      coin_req = 2'b00; tick(2);
      coin_req = 2'b01; tick(2);
      coin_req = 2'b00; tick(4);
      chk("t6_pending_q", coin_pending, 3);
      credit_light_n = 1'b1;
      tick(3);
      chk("t6_sw_on", coin_sw, 1);
      chk("t6_pending_on", coin_pending, 2);
      tick(5);
      chk("t6_sw_mid", coin_sw, 1);
      reset_n = 1'b0;
      #1;
      chk("t6_sw_async", coin_sw, 0);
      chk("t6_pending_async", coin_pending, 0);
      chk("t6_busy_async", busy, 0);
      tick(2);
      reset_n = 1'b1;
      sw0 = sw_hi;
      tick(20);
      chk("t6_no_pulse", sw_hi - sw0, 0);
      chk("t6_busy_after", busy, 0);
      chk("t6_pending_after", coin_pending, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
